// File: rtl/lfsr_checker_if.sv
// Pattern-checker link bundle: control/seed, received beats, and lock/statistics readback.
// The master side drives the stimulus and the slave side is the checker.
interface lfsr_checker_if #(
  parameter int unsigned LfsrWidth = 64,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned CntWidth  = 32
);
  logic                 start_i;
  logic [LfsrWidth-1:0] seed_i;
  logic                 clear_i;
  logic                 valid_i;
  logic [DataWidth-1:0] data_i;
  logic                 locked_o;
  logic                 lost_o;
  logic                 err_o;
  logic [CntWidth-1:0]  err_cnt_o;
  logic [CntWidth-1:0]  beat_cnt_o;

  modport master (
    output start_i, seed_i, clear_i, valid_i, data_i,
    input  locked_o, lost_o, err_o, err_cnt_o, beat_cnt_o
  );

  modport slave (
    input  start_i, seed_i, clear_i, valid_i, data_i,
    output locked_o, lost_o, err_o, err_cnt_o, beat_cnt_o
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for a Galois-LFSR pattern stream: tracks the expected sequence,
// counts beats and mismatches, and declares loss of lock after a run of bad beats.
module lfsr_checker #(
  parameter int unsigned LfsrWidth  = 64,
  parameter int unsigned DataWidth  = 8,
  parameter logic [63:0] Mask       = 64'h8000_0000_0000_19E2,
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned LossThresh = 8
) (
  input logic         clk_i,
  input logic         rst_ni,
  lfsr_checker_if.slave bus
);

  localparam int unsigned ConsecW = $clog2(LossThresh + 1);

  typedef enum logic [1:0] {IDLE, CHECK, LOST} state_e;

  state_e               state_q;
  logic [LfsrWidth-1:0] exp_q, exp_d;
  logic [CntWidth-1:0]  err_cnt_q, beat_cnt_q;
  logic [ConsecW-1:0]   consec_q, consec_inc;
  logic                 locked_q, lost_q, err_q;
  logic                 mismatch;

  always_comb begin
    exp_d      = (exp_q >> 1) ^ ({LfsrWidth{exp_q[0]}} & Mask[LfsrWidth-1:0]);
    mismatch   = (bus.data_i != exp_q[DataWidth-1:0]);
    consec_inc = consec_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      exp_q      <= '1;
      err_cnt_q  <= '0;
      beat_cnt_q <= '0;
      consec_q   <= '0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.start_i) begin
        exp_q      <= bus.seed_i;
        err_cnt_q  <= '0;
        beat_cnt_q <= '0;
        consec_q   <= '0;
        // An all-zero seed would lock the LFSR at zero, so it is treated as lost.
        if (bus.seed_i == '0) begin
          state_q  <= LOST;
          locked_q <= 1'b0;
          lost_q   <= 1'b1;
        end else begin
          state_q  <= CHECK;
          locked_q <= 1'b1;
          lost_q   <= 1'b0;
        end
      end else if (bus.clear_i) begin
        err_cnt_q  <= '0;
        beat_cnt_q <= '0;
        consec_q   <= '0;
        if (state_q == CHECK && bus.valid_i) exp_q <= exp_d;
      end else if (state_q == CHECK && bus.valid_i) begin
        exp_q <= exp_d;
        if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
        if (mismatch) begin
          err_q    <= 1'b1;
          consec_q <= consec_inc;
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          if (consec_inc == ConsecW'(LossThresh)) begin
            state_q  <= LOST;
            locked_q <= 1'b0;
            lost_q   <= 1'b1;
          end
        end else begin
          consec_q <= '0;
        end
      end
    end
  end

  assign bus.locked_o   = locked_q;
  assign bus.lost_o     = lost_q;
  assign bus.err_o      = err_q;
  assign bus.err_cnt_o  = err_cnt_q;
  assign bus.beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed plus randomized bench for lfsr_checker, with a behavioural stream/statistics model.
module tb_lfsr_checker;

  localparam logic [63:0] MASK = 64'h8000_0000_0000_19E2;
  localparam longint unsigned BIG_MAX = 64'h0000_0000_FFFF_FFFF;
  localparam longint unsigned SMALL_MAX = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if #(.LfsrWidth(64), .DataWidth(8), .CntWidth(32)) bus ();
  lfsr_checker_if #(.LfsrWidth(64), .DataWidth(8), .CntWidth(2))  bus2 ();

  lfsr_checker #(.LfsrWidth(64), .DataWidth(8), .Mask(MASK), .CntWidth(32), .LossThresh(8))
    dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  lfsr_checker #(.LfsrWidth(64), .DataWidth(8), .Mask(MASK), .CntWidth(2), .LossThresh(8))
    dut2 (.clk_i(clk), .rst_ni(rst_ni), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0]     m_exp;
  longint unsigned m_beat, m_err;
  int              m_consec;
  bit              m_locked, m_lost;

  function automatic logic [63:0] next_val(input logic [63:0] s);
    logic [63:0] r;
    r = s / 2;
    if (s % 2 == 1) r = r ^ MASK;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input bit exp_err);
    chk({tag, ".locked"}, 64'(bus.locked_o), 64'(m_locked));
    chk({tag, ".lost"}, 64'(bus.lost_o), 64'(m_lost));
    chk({tag, ".err"}, 64'(bus.err_o), 64'(exp_err));
    chk({tag, ".beat_cnt"}, 64'(bus.beat_cnt_o), m_beat);
    chk({tag, ".err_cnt"}, 64'(bus.err_cnt_o), m_err);
  endtask

  task automatic model_reset();
    m_exp = '1; m_beat = 0; m_err = 0; m_consec = 0; m_locked = 0; m_lost = 0;
  endtask

  task automatic do_start(input logic [63:0] seed, input bit with_beat, input logic [7:0] d);
    bus.start_i = 1'b1; bus.seed_i = seed; bus.valid_i = with_beat; bus.data_i = d;
    tick();
    bus.start_i = 1'b0; bus.valid_i = 1'b0;
    m_exp = seed; m_beat = 0; m_err = 0; m_consec = 0;
    m_locked = (seed != 0); m_lost = (seed == 0);
    chk_all("start", 1'b0);
  endtask

  task automatic do_beat(input logic [7:0] d);
    bit e;
    e = 1'b0;
    bus.valid_i = 1'b1; bus.data_i = d;
    tick();
    bus.valid_i = 1'b0;
    if (m_locked) begin
      e = (d != m_exp[7:0]);
      m_exp = next_val(m_exp);
      if (m_beat < BIG_MAX) m_beat++;
      if (e) begin
        if (m_err < BIG_MAX) m_err++;
        m_consec++;
        if (m_consec >= 8) begin m_locked = 0; m_lost = 1; end
      end else m_consec = 0;
    end
    chk_all("beat", e);
  endtask

  task automatic do_clear(input bit v, input logic [7:0] d);
    bus.clear_i = 1'b1; bus.valid_i = v; bus.data_i = d;
    tick();
    bus.clear_i = 1'b0; bus.valid_i = 1'b0;
    m_beat = 0; m_err = 0; m_consec = 0;
    if (m_locked && v) m_exp = next_val(m_exp);
    chk_all("clear", 1'b0);
  endtask

  initial begin
    logic [63:0] e2;
    int pulses;
    int r;

    bus.start_i = 0; bus.seed_i = '0; bus.clear_i = 0; bus.valid_i = 0; bus.data_i = '0;
    bus2.start_i = 0; bus2.seed_i = '0; bus2.clear_i = 0; bus2.valid_i = 0; bus2.data_i = '0;
    model_reset();
    tick(); tick();
    chk_all("reset", 1'b0);
    rst_ni = 1'b1;
    tick();
    do_beat(8'hFF);              // ignored in IDLE
    chk("idle.ignored", 64'(bus.beat_cnt_o), 64'd0);

    // 1: clean stream FF,1D,EC
    do_start('1, 1'b0, 8'h00);
    do_beat(8'hFF); do_beat(8'h1D); do_beat(8'hEC);
    chk("t1.beat_cnt", 64'(bus.beat_cnt_o), 64'd3);

    // 2: single bad beat
    do_start('1, 1'b0, 8'h00);
    do_beat(8'hFF); do_beat(8'h00); do_beat(8'hEC);
    chk("t2.err_cnt", 64'(bus.err_cnt_o), 64'd1);
    chk("t2.locked", 64'(bus.locked_o), 64'd1);

    // 3: eight bad beats -> LOST; extra beats frozen
    do_start('1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) do_beat(8'h00);
    chk("t3.lost", 64'(bus.lost_o), 64'd1);
    do_beat(8'h00); do_beat(8'h55);
    chk("t3.beat_frozen", 64'(bus.beat_cnt_o), 64'd8);

    // 4: restart from LOST
    do_start('1, 1'b0, 8'h00);
    do_beat(8'hFF); do_beat(8'h1D);
    chk("t4.beat_cnt", 64'(bus.beat_cnt_o), 64'd2);

    // 5: beat in start cycle discarded
    do_start('1, 1'b1, 8'hFF);
    do_beat(8'hFF);
    chk("t5.beat_cnt", 64'(bus.beat_cnt_o), 64'd1);
    chk("t5.err_cnt", 64'(bus.err_cnt_o), 64'd0);

    // zero seed goes to LOST
    do_start('0, 1'b0, 8'h00);
    do_beat(8'h00);

    // clear with a same-cycle beat advances the LFSR only
    do_start('1, 1'b0, 8'h00);
    do_beat(8'hFF);
    do_clear(1'b1, 8'h1D);
    do_beat(8'hEC);

    // randomized traffic against the model
    do_start({$urandom, $urandom} | 64'h1, 1'b0, 8'h00);
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 11));
      if (m_lost) do_start({$urandom, $urandom} | 64'h1, 1'b0, 8'h00);
      else if (r == 0) do_clear(1'($urandom_range(0, 1)), 8'($urandom));
      else if (r < 9) do_beat(m_exp[7:0]);
      else do_beat(8'($urandom));
    end

    // 6: 2-bit counters saturate, err_o keeps pulsing
    bus2.start_i = 1'b1; bus2.seed_i = '1;
    tick();
    bus2.start_i = 1'b0;
    e2 = '1; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      bus2.valid_i = 1'b1; bus2.data_i = ~e2[7:0];
      tick();
      bus2.valid_i = 1'b0;
      e2 = next_val(e2);
      if (bus2.err_o) pulses++;
      chk("t6.err_cnt", 64'(bus2.err_cnt_o), (i + 1 < 3) ? 64'(i + 1) : 64'(SMALL_MAX));
    end
    tick();
    chk("t6.err_low", 64'(bus2.err_o), 64'd0);
    chk("t6.pulses", 64'(pulses), 64'd5);
    chk("t6.beat_cnt", 64'(bus2.beat_cnt_o), 64'(SMALL_MAX));
    chk("t6.locked", 64'(bus2.locked_o), 64'd1);

    // 7: asynchronous reset mid-stream
    do_start('1, 1'b0, 8'h00);
    do_beat(8'hFF); do_beat(8'h00);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk_all("t7.async", 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    do_beat(8'hFF); do_beat(8'h1D);
    chk("t7.ignored", 64'(bus.beat_cnt_o), 64'd0);
    do_start('1, 1'b0, 8'h00);
    do_beat(8'hFF); do_beat(8'h1D); do_beat(8'hEC);
    chk("t7.resume", 64'(bus.beat_cnt_o), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
